// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall control.
// Keeps shadow EX/MEM/WB dest fields; datapath supplies ID fields only.
module fwd_hazard_ctrl #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall_active
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_dst_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
  } ex_src_t;

  // Later stages only ever feed forwarding, so mem_read is not carried.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } dst_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  ex_dst_t    ex_d;
  ex_src_t    ex_s;
  dst_t       mem_d;
  dst_t       wb_d;
  logic       hazard;
  logic       in_stall;
  logic       hit_rs;
  logic       hit_rt;

  // STALL with cnt==0 is only the exit check and behaves like RUN.
  assign in_stall = (state == STALL) && (cnt != 3'd0);

  assign hit_rs = id_use_rs && (id_rs == ex_d.rd);
  assign hit_rt = id_use_rt && (id_rt == ex_d.rd);

  assign hazard = id_valid && ex_d.valid && ex_d.mem_read &&
                  (ex_d.rd != '0) && (hit_rs || hit_rt);

  assign stall_active = (state == STALL);

  function automatic logic [1:0] fsel(
    input logic              use_r,
    input logic [REG_AW-1:0] r,
    input dst_t              m,
    input dst_t              w
  );
    logic [1:0] s;
    s = 2'b00;
    if (use_r && m.valid && m.reg_write &&
        (m.rd != '0) && (m.rd == r))
      s = 2'b01;
    else if (use_r && w.valid && w.reg_write &&
             (w.rd != '0) && (w.rd == r))
      s = 2'b10;
    return s;
  endfunction

  // Operand mux selects from registered shadow state only.
  always_comb begin
    fwd_sel_a = fsel(ex_s.use_rs, ex_s.rs, mem_d, wb_d);
    fwd_sel_b = fsel(ex_s.use_rt, ex_s.rt, mem_d, wb_d);
  end

  // Pipeline write enables: reset, freeze, flush, stall, run.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b1;
    if (rst_n) begin
      if (ext_stall) begin
        idex_bubble = 1'b0;
      end else if (flush) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end else if (in_stall || hazard) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = !id_valid;
      end
    end
  end

  // Shadow EX/MEM/WB fields advance unless frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_d  <= '0;
      ex_s  <= '0;
      mem_d <= '0;
      wb_d  <= '0;
    end else if (!ext_stall) begin
      wb_d            <= mem_d;
      mem_d.valid     <= ex_d.valid;
      mem_d.rd        <= ex_d.rd;
      mem_d.reg_write <= ex_d.reg_write;
      if (idex_bubble) begin
        ex_d <= '0;
        ex_s <= '0;
      end else begin
        ex_d.valid     <= id_valid;
        ex_d.rd        <= id_rd;
        ex_d.reg_write <= id_reg_write;
        ex_d.mem_read  <= id_mem_read;
        ex_s.rs        <= id_rs;
        ex_s.rt        <= id_rt;
        ex_s.use_rs    <= id_use_rs;
        ex_s.use_rt    <= id_use_rt;
      end
    end
  end

  // Load-use stall FSM with bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else if (!ext_stall) begin
      if (flush) begin
        state <= RUN;
        cnt   <= 3'd0;
      end else if (in_stall) begin
        cnt   <= cnt - 3'd1;
      end else if (hazard) begin
        state <= STALL;
        cnt   <= CNT_INIT;
      end else begin
        state <= RUN;
      end
    end
  end

endmodule
